// File: rtl/agc_gain_ctrl_pkg.sv
// Shared definitions for the automatic gain controller: FSM encoding and the
// shift base that ties the gain weighting to the downstream gain multiplier.
package agc_gain_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_ACCUM  = 2'd0,
    ST_CALC   = 2'd1,
    ST_UPDATE = 2'd2
  } agc_state_e;

  // GAIN[7-k] weights the input by 2^-(SHIFT_BASE+k); must match the multiplier.
  localparam int unsigned SHIFT_BASE = 4;

endpackage

// File: rtl/agc_gain_ctrl_if.sv
// Sample/control/status bundle between a channel's datapath and its AGC.
interface agc_gain_ctrl_if;

  logic signed [15:0] SAMPLE_IN;
  logic               SAMPLE_VALID;
  logic               ENABLE;
  logic        [7:0]  MANUAL_GAIN;
  logic        [15:0] TARGET;
  logic        [15:0] HYST;
  logic        [7:0]  GAIN;
  logic               GAIN_VALID;
  logic        [15:0] PEAK;

  modport master (
    output SAMPLE_IN, SAMPLE_VALID, ENABLE, MANUAL_GAIN, TARGET, HYST,
    input  GAIN, GAIN_VALID, PEAK
  );

  modport slave (
    input  SAMPLE_IN, SAMPLE_VALID, ENABLE, MANUAL_GAIN, TARGET, HYST,
    output GAIN, GAIN_VALID, PEAK
  );

endinterface

// File: rtl/agc_gain_ctrl_gain_mac_seq.sv
// Sequential shift-add: 8-cycle counterpart of the combinational gain
// multiplier, predicting the post-gain value of an unsigned magnitude.
module gain_mac_seq
  import agc_gain_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] mag_i,
  input  logic [7:0]  gain_i,
  output logic [15:0] result_o,
  output logic        done_o
);

  logic        busy_q, busy_d;
  logic [2:0]  k_q, k_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] term;

  // Weighted term contributed by gain bit 7-k on the current step
  always_comb begin
    term = '0;
    if (gain_i[3'd7 - k_q]) begin
      term = mag_i >> (SHIFT_BASE + 32'(k_q));
    end
  end

  // Step sequencing: start clears the sum, then one gain bit per cycle
  always_comb begin
    busy_d = busy_q;
    k_d    = k_q;
    acc_d  = acc_q;
    if (start_i) begin
      busy_d = 1'b1;
      k_d    = 3'd0;
      acc_d  = '0;
    end else if (busy_q) begin
      acc_d = acc_q + term;
      k_d   = k_q + 3'd1;
      if (k_q == 3'd7) begin
        busy_d = 1'b0;
      end
    end
  end

  // Control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      k_q    <= 3'd0;
    end else begin
      busy_q <= busy_d;
      k_q    <= k_d;
    end
  end

  // Accumulator is always cleared by start before use, so it needs no reset
  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  // done marks the cycle whose closing edge adds the last term
  assign done_o   = busy_q && (k_q == 3'd7);
  assign result_o = acc_q;

endmodule

// File: rtl/agc_gain_ctrl.sv
// Automatic gain controller: windowed peak detection, predicted post-gain
// peak via gain_mac_seq, and attack/release/hold stepping of GAIN.
module agc_gain_ctrl
  import agc_gain_ctrl_pkg::*;
#(
  parameter int unsigned WINDOW       = 256,
  parameter logic [7:0]  INIT_GAIN    = 8'd128,
  parameter logic [7:0]  GAIN_MIN     = 8'd1,
  parameter logic [7:0]  ATTACK_STEP  = 8'd8,
  parameter logic [7:0]  RELEASE_STEP = 8'd1
) (
  input  logic           CLK,
  input  logic           RST_N,
  agc_gain_ctrl_if.slave bus
);

  localparam logic [15:0] WIN_LAST = 16'(WINDOW - 1);

  agc_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] run_pk_q, run_pk_d;
  logic [15:0] peak_q, peak_d;
  logic [7:0]  gain_q, gain_d;
  logic        gv_q, gv_d;
  logic [15:0] mag, pk_max, pred;
  logic        win_close, mac_start, mac_done;

  // |s| with the single unrepresentable value -32768 clipped to 32767
  function automatic logic [15:0] sat_abs(input logic signed [15:0] s);
    if (s == 16'sh8000) return 16'h7FFF;
    if (s < 16'sd0)     return $unsigned(-s);
    return $unsigned(s);
  endfunction

  // Attack step with a floor, evaluated in 9 bits so it cannot wrap
  function automatic logic [7:0] attack_gain(input logic [7:0] g);
    logic [8:0] diff;
    diff = {1'b0, g} - {1'b0, ATTACK_STEP};
    if (diff[8] || (diff[7:0] < GAIN_MIN)) return GAIN_MIN;
    return diff[7:0];
  endfunction

  // Release step saturating at full scale
  function automatic logic [7:0] release_gain(input logic [7:0] g);
    logic [8:0] sum;
    sum = {1'b0, g} + {1'b0, RELEASE_STEP};
    if (sum[8]) return 8'hFF;
    return sum[7:0];
  endfunction

  assign mag       = sat_abs(bus.SAMPLE_IN);
  assign pk_max    = (mag > run_pk_q) ? mag : run_pk_q;
  assign win_close = bus.ENABLE && bus.SAMPLE_VALID && (cnt_q == WIN_LAST);
  assign mac_start = win_close && (state_q == ST_ACCUM);

  gain_mac_seq u_mac (
    .clk      (CLK),
    .rst_n    (RST_N),
    .start_i  (mac_start),
    .mag_i    (peak_q),
    .gain_i   (gain_q),
    .result_o (pred),
    .done_o   (mac_done)
  );

  // Window accumulation runs in every automatic state; manual mode clears it
  always_comb begin
    cnt_d    = cnt_q;
    run_pk_d = run_pk_q;
    peak_d   = peak_q;
    if (!bus.ENABLE) begin
      cnt_d    = '0;
      run_pk_d = '0;
    end else if (bus.SAMPLE_VALID) begin
      if (cnt_q == WIN_LAST) begin
        peak_d   = pk_max;
        cnt_d    = '0;
        run_pk_d = '0;
      end else begin
        cnt_d    = cnt_q + 16'd1;
        run_pk_d = pk_max;
      end
    end
  end

  // FSM next state and gain selection; dropping ENABLE aborts silently
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    gv_d    = 1'b0;
    if (!bus.ENABLE) begin
      state_d = ST_ACCUM;
      gain_d  = bus.MANUAL_GAIN;
    end else begin
      case (state_q)
        ST_ACCUM:  if (win_close) state_d = ST_CALC;
        ST_CALC:   if (mac_done)  state_d = ST_UPDATE;
        ST_UPDATE: begin
          state_d = ST_ACCUM;
          gv_d    = 1'b1;
          if (pred > bus.TARGET) begin
            gain_d = attack_gain(gain_q);
          end else if (({1'b0, pred} + {1'b0, bus.HYST}) < {1'b0, bus.TARGET}) begin
            gain_d = release_gain(gain_q);
          end
        end
        default:   state_d = ST_ACCUM;
      endcase
    end
  end

  // State registers with asynchronous return to reset values
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_ACCUM;
      cnt_q    <= '0;
      run_pk_q <= '0;
      peak_q   <= '0;
      gain_q   <= INIT_GAIN;
      gv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      run_pk_q <= run_pk_d;
      peak_q   <= peak_d;
      gain_q   <= gain_d;
      gv_q     <= gv_d;
    end
  end

  assign bus.GAIN       = gain_q;
  assign bus.GAIN_VALID = gv_q;
  assign bus.PEAK       = peak_q;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Directed + randomized bench for agc_gain_ctrl with a behavioural AGC model.
module tb_agc_gain_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, rst2_n;
  logic signed [15:0] smp;
  logic               vld, en;
  logic        [7:0]  mgain_in;
  logic        [15:0] hyst, tgt0, tgt1, tgt2;

  int checks = 0;
  int errors = 0;
  int m0, m1, m2;
  int exp_peak;
  bit seen_gv0;
  bit early;
  int pk_saved;

  agc_gain_ctrl_if if0 ();
  agc_gain_ctrl_if if1 ();
  agc_gain_ctrl_if if2 ();

  assign if0.SAMPLE_IN = smp;  assign if1.SAMPLE_IN = smp;  assign if2.SAMPLE_IN = smp;
  assign if0.SAMPLE_VALID = vld; assign if1.SAMPLE_VALID = vld; assign if2.SAMPLE_VALID = vld;
  assign if0.ENABLE = en;      assign if1.ENABLE = en;      assign if2.ENABLE = en;
  assign if0.MANUAL_GAIN = mgain_in; assign if1.MANUAL_GAIN = mgain_in; assign if2.MANUAL_GAIN = mgain_in;
  assign if0.HYST = hyst;      assign if1.HYST = hyst;      assign if2.HYST = hyst;
  assign if0.TARGET = tgt0;    assign if1.TARGET = tgt1;    assign if2.TARGET = tgt2;

  agc_gain_ctrl u0 (.CLK(clk), .RST_N(rst_n), .bus(if0));

  agc_gain_ctrl #(.WINDOW(16), .INIT_GAIN(8'd254), .RELEASE_STEP(8'd4))
    u1 (.CLK(clk), .RST_N(rst2_n), .bus(if1));

  agc_gain_ctrl #(.WINDOW(16), .INIT_GAIN(8'd5), .ATTACK_STEP(8'd8))
    u2 (.CLK(clk), .RST_N(rst2_n), .bus(if2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int mag_of(input int s);
    int m;
    m = (s < 0) ? -s : s;
    return (m > 32767) ? 32767 : m;
  endfunction

  // Predicted post-gain peak: sum of peak/2^(4+k) over set gain bits 7-k
  function automatic int model_pred(input int peak, input int g);
    int p;
    p = 0;
    for (int k = 0; k < 8; k++) begin
      if (((g >> (7 - k)) & 1) == 1) p += peak >> (4 + k);
    end
    return p;
  endfunction

  function automatic int model_next(input int g, input int pred, input int target,
                                    input int hy, input int atk, input int rel, input int gmin);
    if (pred > target) return (g - atk < gmin) ? gmin : g - atk;
    if (pred + hy < target) return (g + rel > 255) ? 255 : g + rel;
    return g;
  endfunction

  // Feed n accepted samples; one random slot carries 'special'. Ends #1 after
  // the edge that accepts the window-closing sample.
  task automatic drive_win(input int n, input int special, input int lo_max,
                           input bit full, input bit gaps);
    int pos;
    int s;
    pos = int'($urandom_range(n - 1, 0));
    exp_peak = 0;
    seen_gv0 = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(3, 0) == 0)) begin
        vld = 1'b0;
        step();
        if (if0.GAIN_VALID !== 1'b0) seen_gv0 = 1'b1;
      end
      if (i == pos) s = special;
      else if (full) s = ($urandom_range(1, 0) == 1) ? mag_of(special) : -mag_of(special);
      else begin
        s = int'($urandom_range(lo_max, 0));
        if ($urandom_range(1, 0) == 1) s = -s;
      end
      smp = 16'(s);
      vld = 1'b1;
      step();
      if (mag_of(s) > exp_peak) exp_peak = mag_of(s);
      if (if0.GAIN_VALID !== 1'b0) seen_gv0 = 1'b1;
    end
    vld = 1'b0;
  endtask

  // Check u0 from the window-closing edge N through N+10 against the model
  task automatic check_u0(input string tag);
    int pred, nxt;
    bit bad;
    pred = model_pred(exp_peak, m0);
    nxt  = model_next(m0, pred, int'(tgt0), int'(hyst), 8, 1, 1);
    chk({tag, "_peak"}, 32'(if0.PEAK), 32'(exp_peak));
    chk({tag, "_quiet"}, 32'(seen_gv0), 32'd0);
    bad = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (if0.GAIN_VALID !== 1'b0 || if0.GAIN !== 8'(m0)) bad = 1'b1;
    end
    chk({tag, "_busy"}, 32'(bad), 32'd0);
    step();
    chk({tag, "_gv"}, 32'(if0.GAIN_VALID), 32'd1);
    chk({tag, "_gain"}, 32'(if0.GAIN), 32'(nxt));
    step();
    chk({tag, "_gvoff"}, 32'(if0.GAIN_VALID), 32'd0);
    m0 = nxt;
  endtask

  initial begin
    int p1, p2, n1, n2, sp, lo;
    rst_n = 1'b0; rst2_n = 1'b0;
    smp = '0; vld = 1'b0; en = 1'b1; mgain_in = 8'd0;
    hyst = 16'd256; tgt0 = 16'd2000; tgt1 = 16'hFFFF; tgt2 = 16'd0;
    m0 = 128; m1 = 254; m2 = 5;
    repeat (3) step();
    chk("rst_gain", 32'(if0.GAIN), 32'd128);
    chk("rst_peak", 32'(if0.PEAK), 32'd0);
    chk("rst_gv", 32'(if0.GAIN_VALID), 32'd0);
    chk("rst_gain_hi", 32'(if1.GAIN), 32'd254);
    chk("rst_gain_lo", 32'(if2.GAIN), 32'd5);

    // Saturation limits on the 16-sample instances while u0 stays in reset
    rst2_n = 1'b1;
    step();
    for (int w = 0; w < 2; w++) begin
      drive_win(16, 16384, 16000, 1'b0, 1'b0);
      p1 = model_pred(exp_peak, m1);
      n1 = model_next(m1, p1, int'(tgt1), int'(hyst), 8, 4, 1);
      p2 = model_pred(exp_peak, m2);
      n2 = model_next(m2, p2, int'(tgt2), int'(hyst), 8, 1, 1);
      repeat (9) step();
      chk("sat_hi_gv", 32'(if1.GAIN_VALID), 32'd1);
      chk("sat_hi_gain", 32'(if1.GAIN), 32'(n1));
      chk("sat_lo_gv", 32'(if2.GAIN_VALID), 32'd1);
      chk("sat_lo_gain", 32'(if2.GAIN), 32'(n2));
      m1 = n1; m2 = n2;
    end
    chk("sat_hi_final", 32'(if1.GAIN), 32'd255);
    chk("sat_lo_final", 32'(if2.GAIN), 32'd1);
    rst2_n = 1'b0;

    // Release: +-16384 throughout, pred 1024 well below 2000-256
    rst_n = 1'b1;
    drive_win(256, 16384, 0, 1'b1, 1'b0);
    check_u0("release");
    chk("release_129", 32'(if0.GAIN), 32'd129);

    // Asynchronous reset mid-window, checked before any clock edge
    vld = 1'b1; smp = 16'sd1000;
    repeat (10) step();
    vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_gain", 32'(if0.GAIN), 32'd128);
    chk("async_peak", 32'(if0.PEAK), 32'd0);
    chk("async_gv", 32'(if0.GAIN_VALID), 32'd0);
    step();
    rst_n = 1'b1;
    m0 = 128;

    // Attack: one -32768 sample, peak saturates to 32767, pred 2047
    tgt0 = 16'd1000;
    drive_win(256, -32768, 20000, 1'b0, 1'b1);
    check_u0("attack");
    chk("attack_120", 32'(if0.GAIN), 32'd120);

    // Manual override, then back to automatic at 128
    en = 1'b0; mgain_in = 8'h3C;
    step();
    chk("man_gain", 32'(if0.GAIN), 32'h3C);
    chk("man_gv", 32'(if0.GAIN_VALID), 32'd0);
    chk("man_peak", 32'(if0.PEAK), 32'd32767);
    mgain_in = 8'd128;
    step();
    en = 1'b1;
    m0 = 128;

    // Hold band: pred 1024 sits between 1100-200 and 1100
    tgt0 = 16'd1100; hyst = 16'd200;
    drive_win(256, 16384, 16000, 1'b0, 1'b1);
    check_u0("hold");

    // Abort during CALC; loud samples taken during CALC must not leak
    tgt0 = 16'd3000; hyst = 16'd100;
    drive_win(256, 8000, 7000, 1'b0, 1'b0);
    chk("abort_peak", 32'(if0.PEAK), 32'(exp_peak));
    pk_saved = exp_peak;
    smp = 16'sd32767; vld = 1'b1;
    repeat (4) step();
    vld = 1'b0;
    en = 1'b0; mgain_in = 8'd200;
    early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (if0.GAIN_VALID !== 1'b0) early = 1'b1;
    end
    chk("abort_nopulse", 32'(early), 32'd0);
    chk("abort_manual", 32'(if0.GAIN), 32'd200);
    chk("abort_peak_hold", 32'(if0.PEAK), 32'(pk_saved));
    en = 1'b1;
    m0 = 200;
    drive_win(256, 6000, 5000, 1'b0, 1'b0);
    check_u0("after_abort");

    // Randomized windows, targets and hysteresis
    for (int r = 0; r < 4; r++) begin
      tgt0 = 16'($urandom_range(3000, 200));
      hyst = 16'($urandom_range(400, 0));
      sp = int'($urandom_range(32767, 1));
      lo = int'($urandom_range(sp, 0));
      if ($urandom_range(1, 0) == 1) sp = -sp;
      drive_win(256, sp, lo, 1'b0, 1'b1);
      check_u0($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
